// File: rtl/sram_march_bist_if.sv
// RAM-side bus of the March BIST: the BIST drives address/data/write, the RAM returns read data.
// The master modport is the BIST; the slave modport is the SRAM (or its model).
interface sram_march_bist_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  ram_write;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;

   modport master (
      output ram_write,
      output ram_addr,
      output ram_wdata,
      input  ram_rdata
   );

   modport slave (
      input  ram_write,
      input  ram_addr,
      input  ram_wdata,
      output ram_rdata
   );
endinterface

// File: rtl/sram_march_bist.sv
// 4-element March BIST driver for a single-port synchronous SRAM with 1-cycle read latency.
// Reports pass, or the address/data/element of the first mismatching read.
module sram_march_bist #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] pattern,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic [DATA_WIDTH-1:0] fail_rdata,
   output logic [DATA_WIDTH-1:0] fail_expect,
   output logic [1:0]            fail_elem,
   sram_march_bist_if.master     ram
);

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [3:0] {
      StIdle, StM0W, StM1Rd, StM1Cw, StM2Rd, StM2Cw, StM3Rd, StM3C, StFinish, StDone, StFail
   } state_e;

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] pat_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wr_q;
   logic                  busy_q, done_q, fail_q;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [DATA_WIDTH-1:0] fail_rdata_q, fail_expect_q;
   logic [1:0]            fail_elem_q;

   logic                  cmp_state;
   logic [DATA_WIDTH-1:0] exp_data;
   logic [1:0]            cur_elem;
   logic                  mismatch;

   always_comb begin
      cmp_state = 1'b0;
      exp_data  = pat_q;
      cur_elem  = 2'd0;
      unique case (state_q)
         StM1Cw: begin
            cmp_state = 1'b1;
            cur_elem  = 2'd1;
         end
         StM2Cw: begin
            cmp_state = 1'b1;
            exp_data  = ~pat_q;
            cur_elem  = 2'd2;
         end
         StM3C: begin
            cmp_state = 1'b1;
            cur_elem  = 2'd3;
         end
         default: ;
      endcase
      mismatch = cmp_state && (ram.ram_rdata != exp_data);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         addr_q        <= '0;
         pat_q         <= '0;
         wdata_q       <= '0;
         wr_q          <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         fail_q        <= 1'b0;
         fail_addr_q   <= '0;
         fail_rdata_q  <= '0;
         fail_expect_q <= '0;
         fail_elem_q   <= '0;
      end else if (mismatch) begin
         // Write in this cycle is already gated off combinationally; freeze the RAM port.
         state_q       <= StFail;
         wr_q          <= 1'b0;
         busy_q        <= 1'b0;
         fail_q        <= 1'b1;
         fail_addr_q   <= addr_q;
         fail_rdata_q  <= ram.ram_rdata;
         fail_expect_q <= exp_data;
         fail_elem_q   <= cur_elem;
      end else begin
         unique case (state_q)
            StIdle, StDone, StFail: begin
               if (start) begin
                  state_q       <= StM0W;
                  pat_q         <= pattern;
                  addr_q        <= '0;
                  wr_q          <= 1'b1;
                  wdata_q       <= pattern;
                  busy_q        <= 1'b1;
                  done_q        <= 1'b0;
                  fail_q        <= 1'b0;
                  fail_addr_q   <= '0;
                  fail_rdata_q  <= '0;
                  fail_expect_q <= '0;
                  fail_elem_q   <= '0;
               end
            end
            StM0W: begin
               if (addr_q == LastAddr) begin
                  state_q <= StM1Rd;
                  addr_q  <= '0;
                  wr_q    <= 1'b0;
               end else begin
                  addr_q <= addr_q + 1'b1;
               end
            end
            StM1Rd: begin
               state_q <= StM1Cw;
               wr_q    <= 1'b1;
               wdata_q <= ~pat_q;
            end
            StM1Cw: begin
               wr_q <= 1'b0;
               if (addr_q == LastAddr) begin
                  state_q <= StM2Rd;
                  addr_q  <= LastAddr;
               end else begin
                  state_q <= StM1Rd;
                  addr_q  <= addr_q + 1'b1;
               end
            end
            StM2Rd: begin
               state_q <= StM2Cw;
               wr_q    <= 1'b1;
               wdata_q <= pat_q;
            end
            StM2Cw: begin
               wr_q <= 1'b0;
               if (addr_q == '0) begin
                  state_q <= StM3Rd;
                  addr_q  <= LastAddr;
               end else begin
                  state_q <= StM2Rd;
                  addr_q  <= addr_q - 1'b1;
               end
            end
            StM3Rd: state_q <= StM3C;
            StM3C: begin
               if (addr_q == '0) begin
                  state_q <= StFinish;
               end else begin
                  state_q <= StM3Rd;
                  addr_q  <= addr_q - 1'b1;
               end
            end
            StFinish: begin
               state_q <= StDone;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ram.ram_write = wr_q & ~mismatch;
   assign ram.ram_addr  = addr_q;
   assign ram.ram_wdata = wdata_q;

   assign busy        = busy_q;
   assign done        = done_q;
   assign fail        = fail_q;
   assign fail_addr   = fail_addr_q;
   assign fail_rdata  = fail_rdata_q;
   assign fail_expect = fail_expect_q;
   assign fail_elem   = fail_elem_q;

endmodule
